// File: rtl/beep_sched.sv
// beep_sched: arbitrates the piezo between two level-held tunes and two queued one-shot beeps.
// Optional build macro BEEP_SCHED_MUTE_EN adds a `mute` input that silences `beep` only.
module beep_sched #(
  parameter int unsigned WRONG_MS = 25,
  parameter int unsigned CORR_MS  = 300,
  parameter int unsigned GAP_MS   = 40
) (
  input  logic       Clk,
  input  logic       rst_n,
  input  logic       tick_ms,
  input  logic       lvl_cong,
  input  logic       lvl_boom,
  input  logic       evt_wrong,
  input  logic       evt_corr,
  input  logic [3:0] tone,
`ifdef BEEP_SCHED_MUTE_EN
  input  logic       mute,
`endif
  output logic [3:0] player_en,
  output logic       beep,
  output logic       busy,
  output logic [1:0] pend_wrong,
  output logic [1:0] pend_corr
);

  typedef enum logic [1:0] {IDLE, EVT, GAP, LVL} state_t;

  localparam logic [9:0] WRONG_LEN = 10'(WRONG_MS);
  localparam logic [9:0] CORR_LEN  = 10'(CORR_MS);
  localparam logic [9:0] GAP_LEN   = 10'(GAP_MS);

  localparam logic [3:0] EN_CONG  = 4'b1000;
  localparam logic [3:0] EN_BOOM  = 4'b0100;
  localparam logic [3:0] EN_WRONG = 4'b0010;
  localparam logic [3:0] EN_CORR  = 4'b0001;

  state_t     state_q, state_d;
  logic [3:0] player_en_q, player_en_d;
  logic [9:0] timer_q, timer_d;
  logic       busy_q, busy_d;
  logic [1:0] pend_wrong_q, pend_wrong_d;
  logic [1:0] pend_corr_q, pend_corr_d;
  logic       dec_wrong, dec_corr;
  logic       inc_wrong, inc_corr;
  logic       lvl_held;

  // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    player_en_d = player_en_q;
    timer_d     = timer_q;
    dec_wrong   = 1'b0;
    dec_corr    = 1'b0;
    lvl_held    = player_en_q[3] ? lvl_cong : lvl_boom;

    unique case (state_q)
      IDLE: begin
        if (lvl_cong) begin
          state_d     = LVL;
          player_en_d = EN_CONG;
        end else if (lvl_boom) begin
          state_d     = LVL;
          player_en_d = EN_BOOM;
        end else if (pend_wrong_q != 2'd0) begin
          state_d     = EVT;
          player_en_d = EN_WRONG;
          timer_d     = WRONG_LEN;
          dec_wrong   = 1'b1;
        end else if (pend_corr_q != 2'd0) begin
          state_d     = EVT;
          player_en_d = EN_CORR;
          timer_d     = CORR_LEN;
          dec_corr    = 1'b1;
        end
      end

      EVT, GAP: begin
        // A level request aborts the running beep or gap; the event is not requeued.
        if (lvl_cong || lvl_boom) begin
          state_d     = LVL;
          player_en_d = lvl_cong ? EN_CONG : EN_BOOM;
          timer_d     = '0;
        end else if (tick_ms) begin
          if (timer_q <= 10'd1) begin
            player_en_d = '0;
            if (state_q == EVT && GAP_LEN != 10'd0) begin
              state_d = GAP;
              timer_d = GAP_LEN;
            end else begin
              state_d = IDLE;
              timer_d = '0;
            end
          end else begin
            timer_d = timer_q - 10'd1;
          end
        end
      end

      LVL: begin
        if (player_en_q[2] && lvl_cong) begin
          player_en_d = EN_CONG;
        end else if (!lvl_held) begin
          state_d     = IDLE;
          player_en_d = '0;
        end
      end

      default: begin
        state_d     = IDLE;
        player_en_d = '0;
        timer_d     = '0;
      end
    endcase

    // A pulse coinciding with a decrement is accepted even when full, so the count stays put.
    inc_wrong = evt_wrong && (pend_wrong_q != 2'd3 || dec_wrong);
    inc_corr  = evt_corr  && (pend_corr_q  != 2'd3 || dec_corr);

    unique case ({inc_wrong, dec_wrong})
      2'b10:   pend_wrong_d = pend_wrong_q + 2'd1;
      2'b01:   pend_wrong_d = pend_wrong_q - 2'd1;
      default: pend_wrong_d = pend_wrong_q;
    endcase

    unique case ({inc_corr, dec_corr})
      2'b10:   pend_corr_d = pend_corr_q + 2'd1;
      2'b01:   pend_corr_d = pend_corr_q - 2'd1;
      default: pend_corr_d = pend_corr_q;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      player_en_q  <= '0;
      timer_q      <= '0;
      busy_q       <= 1'b0;
      pend_wrong_q <= '0;
      pend_corr_q  <= '0;
    end else begin
      state_q      <= state_d;
      player_en_q  <= player_en_d;
      timer_q      <= timer_d;
      busy_q       <= busy_d;
      pend_wrong_q <= pend_wrong_d;
      pend_corr_q  <= pend_corr_d;
    end
  end

  assign player_en  = player_en_q;
  assign busy       = busy_q;
  assign pend_wrong = pend_wrong_q;
  assign pend_corr  = pend_corr_q;

`ifdef BEEP_SCHED_MUTE_EN
  assign beep = (|(player_en_q & tone)) & ~mute;
`else
  assign beep = |(player_en_q & tone);
`endif

endmodule

// File: tb/tb_beep_sched.sv
// Testbench for beep_sched: directed scenarios plus random traffic, checked every cycle
// against an abstract model of who owns the buzzer, how many ms remain, and the queue depths.
module tb_beep_sched;

  localparam int WRONG_MS = 25;
  localparam int CORR_MS  = 300;
  localparam int GAP_MS   = 40;
  localparam int TICK_DIV = 2;

  logic       Clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_ms = 1'b0;
  logic       lvl_cong = 1'b0;
  logic       lvl_boom = 1'b0;
  logic       evt_wrong = 1'b0;
  logic       evt_corr = 1'b0;
  logic [3:0] tone = 4'h0;
  logic       mute = 1'b0;
  logic [3:0] player_en;
  logic       beep;
  logic       busy;
  logic [1:0] pend_wrong;
  logic [1:0] pend_corr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: owner index (3=cong 2=boom 1=wrong 0=corr, -1 none), silent-gap flag,
  // ms left in the current beep or gap, and the two queue depths.
  int m_src = -1;
  bit m_gap = 1'b0;
  int m_left = 0;
  int m_pw = 0;
  int m_pc = 0;

  beep_sched #(.WRONG_MS(WRONG_MS), .CORR_MS(CORR_MS), .GAP_MS(GAP_MS)) dut (
    .Clk        (Clk),
    .rst_n      (rst_n),
    .tick_ms    (tick_ms),
    .lvl_cong   (lvl_cong),
    .lvl_boom   (lvl_boom),
    .evt_wrong  (evt_wrong),
    .evt_corr   (evt_corr),
    .tone       (tone),
`ifdef BEEP_SCHED_MUTE_EN
    .mute       (mute),
`endif
    .player_en  (player_en),
    .beep       (beep),
    .busy       (busy),
    .pend_wrong (pend_wrong),
    .pend_corr  (pend_corr)
  );

  always #10 Clk = ~Clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic model_reset();
    m_src  = -1;
    m_gap  = 1'b0;
    m_left = 0;
    m_pw   = 0;
    m_pc   = 0;
  endtask

  task automatic model_step(input logic c, input logic b, input logic ew, input logic ec, input logic tk);
    int n_src  = m_src;
    int n_left = m_left;
    bit n_gap  = m_gap;
    int take   = -1;
    bit idle   = (m_src < 0) && !m_gap;
    if (m_src >= 2) begin
      if (m_src == 2 && c) n_src = 3;
      else if (!((m_src == 3) ? c : b)) n_src = -1;
    end else if (c || b) begin
      n_src  = c ? 3 : 2;
      n_gap  = 1'b0;
      n_left = 0;
    end else if (idle) begin
      if (m_pw > 0) begin
        n_src = 1; n_left = WRONG_MS; take = 1;
      end else if (m_pc > 0) begin
        n_src = 0; n_left = CORR_MS; take = 0;
      end
    end else if (tk) begin
      n_left = m_left - 1;
      if (n_left == 0) begin
        n_src = -1;
        if (!m_gap && GAP_MS > 0) begin
          n_gap = 1'b1; n_left = GAP_MS;
        end else begin
          n_gap = 1'b0;
        end
      end
    end
    m_pw   = sat3(m_pw + int'(ew) - int'(take == 1));
    m_pc   = sat3(m_pc + int'(ec) - int'(take == 0));
    m_src  = n_src;
    m_gap  = n_gap;
    m_left = n_left;
  endtask

  task automatic check_outputs();
    logic [3:0] exp_en;
    logic       exp_beep;
    bit         muted;
    exp_en = (m_src >= 0) ? 4'(1 << m_src) : 4'h0;
`ifdef BEEP_SCHED_MUTE_EN
    muted = mute;
`else
    muted = 1'b0;
`endif
    exp_beep = (|(exp_en & tone)) && !muted;
    check("player_en", player_en, exp_en);
    check("busy", {3'b0, busy}, {3'b0, (m_src >= 0) || m_gap});
    check("pend_wrong", {2'b0, pend_wrong}, 4'(m_pw));
    check("pend_corr", {2'b0, pend_corr}, 4'(m_pc));
    check("beep", {3'b0, beep}, {3'b0, exp_beep});
  endtask

  // One Clk cycle: drive at the falling edge, check after settling, advance the model at the rising edge.
  task automatic step(input logic c, input logic b, input logic ew, input logic ec, input logic tk);
    @(negedge Clk);
    lvl_cong  = c;
    lvl_boom  = b;
    evt_wrong = ew;
    evt_corr  = ec;
    tick_ms   = tk;
    tone      = 4'($urandom);
    #1;
    check_outputs();
    @(posedge Clk);
    model_step(c, b, ew, ec, tk);
    cyc++;
  endtask

  task automatic run(input int n, input logic c, input logic b);
    for (int i = 0; i < n; i++) step(c, b, 1'b0, 1'b0, (cyc % TICK_DIV) == TICK_DIV - 1);
  endtask

  task automatic pulse(input logic ew, input logic ec, input logic c, input logic b);
    step(c, b, ew, ec, (cyc % TICK_DIV) == TICK_DIV - 1);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst player_en", player_en, 4'h0);
    check("rst beep", {3'b0, beep}, 4'h0);
    check("rst busy", {3'b0, busy}, 4'h0);
    check("rst pend_wrong", {2'b0, pend_wrong}, 4'h0);
    check("rst pend_corr", {2'b0, pend_corr}, 4'h0);
    lvl_cong = 1'b0; lvl_boom = 1'b0; evt_wrong = 1'b0; evt_corr = 1'b0; tick_ms = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit c, b;
    // Initial reset.
    model_reset();
    repeat (2) @(posedge Clk);
    do_reset();

    // 1: single wrong beep, its gap, then idle.
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    run((WRONG_MS + GAP_MS) * TICK_DIV + 10, 1'b0, 1'b0);

    // 2: five back-to-back corr pulses; queue saturates, four beeps play.
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0);
    run(4 * (CORR_MS + GAP_MS) * TICK_DIV + 20, 1'b0, 1'b0);

    // 3: corr aborted by boom after 100 ms, boom held 50 ms, no replay.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    run(100 * TICK_DIV, 1'b0, 1'b0);
    run(50 * TICK_DIV, 1'b0, 1'b1);
    run(20, 1'b0, 1'b0);

    // 4: boom, then cong arrives with two wrong pulses; wrongs play after cong drops.
    run(10, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b1, 1'b1);
    pulse(1'b1, 1'b0, 1'b1, 1'b1);
    run(30, 1'b1, 1'b1);
    run(10, 1'b1, 1'b0);
    run(2 * (WRONG_MS + GAP_MS) * TICK_DIV + 20, 1'b0, 1'b0);

    // 5: reset in the middle of a corr play with more queued.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    run(60, 1'b0, 1'b0);
    do_reset();
    run(50, 1'b0, 1'b0);

`ifdef BEEP_SCHED_MUTE_EN
    // 6: muted wrong beep still consumes its slot.
    mute = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    run((WRONG_MS + GAP_MS) * TICK_DIV + 10, 1'b0, 1'b0);
    mute = 1'b0;
`endif

    // Random traffic: slowly toggling levels, sparse pulses, irregular ticks.
    c = 1'b0;
    b = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 399) == 0) c = ~c;
      if ($urandom_range(0, 299) == 0) b = ~b;
      step(c, b, $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);
    end
    run(20, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
